residual_block_stream: RTL
==========================

// Module: residual_block_stream
// PURPOSE
//  Sequential, handshaked successor to the combinational residual block: one MAC per cycle computes
//  valid (no-pad) KxK conv over C_in channels, adds an identity or 1x1-projection shortcut, requantises,
//  saturates, applies ReLU. Whole tensors move on flat buses under valid/ready; weights via write port.
// PARAMETERS
//  DATA_WIDTH 8  signed activation/weight width
//  IN_CHANNELS 1  input channels (C_in)
//  OUT_CHANNELS 1  output channels (C_out); must equal C_in when USE_PROJECTION_SHORTCUT=0
//  IN_HEIGHT 4 / IN_WIDTH 4  input spatial dims
//  KERNEL_SIZE 2  conv kernel K (square)
//  STRIDE 1  conv stride; OUT_H=(IN_HEIGHT-K)/STRIDE+1, OUT_W likewise
//  USE_PROJECTION_SHORTCUT 1  1: 1x1 conv shortcut with own weights; 0: identity shortcut
//  ACC_WIDTH 24  signed accumulator width
//  SHIFT 0  arithmetic right shift applied to conv accumulator before shortcut add
// PORTS
//  clk  in  1  clock, rising edge
//  rst  in  1  asynchronous, active-low reset
//  in_valid  in  1  input_tensor valid
//  in_ready  out  1  block can accept a tensor (high only in IDLE)
//  input_tensor  in  IN_SIZE*DATA_WIDTH  flat [c][y][x], element i at [i*DW +: DW]
//  out_valid  out  1  output_tensor valid
//  out_ready  in  1  consumer accepts output
//  output_tensor  out  OUT_SIZE*DATA_WIDTH  flat [co][oy][ox], same packing
//  w_we  in  1  weight write strobe
//  w_addr  in  clog2(NW)  0..C_out*C_in*K*K-1 conv [co][ci][ky][kx]; then C_out*C_in proj [co][ci]
//  w_data  in  DATA_WIDTH  signed weight
//  busy  out  1  high in LOAD/CONV/PROJ/WRITE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0, output_tensor=0, all weights=0,
//   counters/accumulator=0. Reset mid-operation aborts; partial results discarded.
//  FSM: IDLE -> (in_valid&in_ready) LOAD: input_tensor captured into internal buffer on that edge.
//   LOAD -> CONV (1 cycle). CONV: one MAC/cycle, C_in*K*K cycles per output element, order ci,ky,kx;
//   pixel x[ci][oy*STRIDE+ky][ox*STRIDE+kx]. -> PROJ if projection else WRITE.
//   PROJ: C_in cycles, sc += x[ci][oy*STRIDE][ox*STRIDE]*wp[co][ci]. Identity: sc = x[co][oy*STRIDE][ox*STRIDE].
//   WRITE (1 cycle): r = (acc>>>SHIFT) + sc at ACC_WIDTH; r<0 -> 0; r>2^(DW-1)-1 -> 2^(DW-1)-1; store
//   element; clear acc/sc; advance ox, then oy, then co. Last element -> DONE, else -> CONV.
//   DONE: out_valid=1, output_tensor stable; on out_valid&out_ready -> IDLE next edge, out_valid=0.
//  Latency from accept edge to out_valid high: 1 + OUT_SIZE*(C_in*K*K + P*C_in + 1) cycles, P=USE_PROJ.
//   Default: 1 + 9*6 = 55 cycles.
//  Products full 2*DW signed, sign-extended into ACC_WIDTH; no overflow checking inside accumulator.
//  Weight writes take effect only in IDLE or DONE; w_we ignored in other states; out-of-range addr ignored.
//  in_ready low outside IDLE; in_valid during busy ignored. out_ready while out_valid=0 ignored.
//  Capture and out handshake cannot coincide (in_ready only in IDLE); no back-to-back overlap.
//  output_tensor changes only in WRITE; holds last result through IDLE until next overwrite.
// TESTING
//  Defaults, conv w=1, proj w=1, input[j]=j -> after 55 cycles out_valid=1; out[0]=10, out[4]=35, out[8]=60.
//  Input all 127, conv w=1, proj w=1 -> every output=127 (635 saturated).
//  Conv w=-1, proj w=0, input[j]=j -> every output=0 (ReLU clamp of negative sums).
//  Hold out_ready=0 20 cycles after out_valid -> out_valid and data stable, in_ready=0; pulse -> IDLE.
//  Drop rst mid-CONV -> out_valid=0, in_ready=1, busy=0 immediately; weights read back as 0 (outputs 0).
//  USE_PROJECTION_SHORTCUT=0, C_in=C_out=2, w_we during CONV -> write ignored; results match golden model.

Source files
------------

// File: rtl/residual_block_stream.sv
// -----------------------------------------------------------------------------
// residual_block_stream
//
// Sequential residual block. A whole input tensor is accepted on a flat bus,
// then a single multiply-accumulate unit walks the valid (no-pad) KxK
// convolution over C_in channels, one MAC per clock. The shortcut is either a
// 1x1 projection conv with its own weights or the identity. Each conv
// accumulator is arithmetically shifted, the shortcut is added, and the sum is
// clamped to [0, 2^(DW-1)-1], which is ReLU plus saturation. The complete
// output tensor is then presented on a flat bus until the consumer takes it.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   in_valid       input tensor offered
//   in_ready       block can take a tensor (high only in IDLE)
//   input_tensor   flat [c][y][x]; element i at [i*DW +: DW]
//   out_valid      output tensor available (DONE)
//   out_ready      consumer takes the output tensor
//   output_tensor  flat [co][oy][ox], same packing
//   w_we           weight write strobe (honoured only in IDLE or DONE)
//   w_addr         conv weights [co][ci][ky][kx] first, then projection [co][ci]
//   w_data         signed weight value
//   busy           high in LOAD / CONV / PROJ / WRITE
//   state_dbg      current FSM state encoding, for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data steady until that edge. Ready
// may be asserted or withdrawn freely. A ready edge while valid is low does
// nothing.
// -----------------------------------------------------------------------------
module residual_block_stream #(
   parameter int DATA_WIDTH              = 8,
   parameter int IN_CHANNELS             = 1,
   parameter int OUT_CHANNELS            = 1,
   parameter int IN_HEIGHT               = 4,
   parameter int IN_WIDTH                = 4,
   parameter int KERNEL_SIZE             = 2,
   parameter int STRIDE                  = 1,
   parameter int USE_PROJECTION_SHORTCUT = 1,
   parameter int ACC_WIDTH               = 24,
   parameter int SHIFT                   = 0,
   localparam int OUT_H    = (IN_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
   localparam int OUT_W    = (IN_WIDTH - KERNEL_SIZE) / STRIDE + 1,
   localparam int IN_SIZE  = IN_CHANNELS * IN_HEIGHT * IN_WIDTH,
   localparam int OUT_SIZE = OUT_CHANNELS * OUT_H * OUT_W,
   localparam int CONV_NW  = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
   localparam int NW       = CONV_NW + OUT_CHANNELS * IN_CHANNELS,
   localparam int AW       = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [IN_SIZE*DATA_WIDTH-1:0]  input_tensor,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_SIZE*DATA_WIDTH-1:0] output_tensor,
   input  logic                           w_we,
   input  logic [AW-1:0]                  w_addr,
   input  logic signed [DATA_WIDTH-1:0]   w_data,
   output logic                           busy,
   output logic [2:0]                     state_dbg
);

   localparam int PLANE = IN_HEIGHT * IN_WIDTH;
   localparam int XI_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
   localparam int OT_W  = $clog2(OUT_SIZE * DATA_WIDTH);
   localparam logic signed [ACC_WIDTH-1:0] MAX_POS =
      ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CONV  = 3'd2,
      S_PROJ  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t state;

   // Captured input tensor and weight store
   logic signed [DATA_WIDTH-1:0] x_buf [IN_SIZE];
   logic signed [DATA_WIDTH-1:0] w_mem [NW];

   // Loop counters: kernel position (ci, ky, kx) and output position (co, oy, ox)
   logic [15:0] ci, ky, kx, co, oy, ox;

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] sc;

   // Datapath selects and results
   int                             x_pos, sc_pos, cw_pos, pw_pos, o_pos;
   logic [XI_W-1:0]                x_idx, sc_idx;
   logic [AW-1:0]                  cw_idx, pw_idx;
   logic [OT_W-1:0]                o_base;
   logic signed [DATA_WIDTH-1:0]   x_sel, w_sel;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext;
   logic signed [ACC_WIDTH-1:0]    sc_eff;
   logic signed [ACC_WIDTH-1:0]    res;
   logic [DATA_WIDTH-1:0]          q;
   logic                           last_tap, last_proj, last_elem;

   assign state_dbg = state;

   // ky and kx are zero outside CONV, so in PROJ x_pos addresses the
   // top-left tap x[ci][oy*S][ox*S], which is what the 1x1 shortcut needs.
   always_comb begin
      x_pos  = int'(ci) * PLANE
             + (int'(oy) * STRIDE + int'(ky)) * IN_WIDTH
             + int'(ox) * STRIDE + int'(kx);
      sc_pos = int'(co) * PLANE
             + int'(oy) * STRIDE * IN_WIDTH
             + int'(ox) * STRIDE;
      cw_pos = ((int'(co) * IN_CHANNELS + int'(ci)) * KERNEL_SIZE + int'(ky))
               * KERNEL_SIZE + int'(kx);
      pw_pos = CONV_NW + int'(co) * IN_CHANNELS + int'(ci);
      o_pos  = int'(co) * OUT_H * OUT_W + int'(oy) * OUT_W + int'(ox);

      x_idx  = XI_W'(x_pos);
      sc_idx = XI_W'(sc_pos);
      cw_idx = AW'(cw_pos);
      pw_idx = AW'(pw_pos);
      o_base = OT_W'(o_pos * DATA_WIDTH);

      x_sel    = x_buf[x_idx];
      w_sel    = (state == S_PROJ) ? w_mem[pw_idx] : w_mem[cw_idx];
      prod     = x_sel * w_sel;
      prod_ext = ACC_WIDTH'(prod);

      if (USE_PROJECTION_SHORTCUT != 0) begin
         sc_eff = sc;
      end else begin
         sc_eff = ACC_WIDTH'(x_buf[sc_idx]);
      end

      // The shift, the add and the clamp all happen at accumulator width,
      // so a large negative conv sum cannot wrap into a positive output.
      res = (acc >>> SHIFT) + sc_eff;
      if (res < 0) begin
         q = '0;
      end else if (res > MAX_POS) begin
         q = MAX_POS[DATA_WIDTH-1:0];
      end else begin
         q = res[DATA_WIDTH-1:0];
      end

      last_tap  = (ci == 16'(IN_CHANNELS - 1)) && (ky == 16'(KERNEL_SIZE - 1)) &&
                  (kx == 16'(KERNEL_SIZE - 1));
      last_proj = (ci == 16'(IN_CHANNELS - 1));
      last_elem = (ox == 16'(OUT_W - 1)) && (oy == 16'(OUT_H - 1)) &&
                  (co == 16'(OUT_CHANNELS - 1));
   end

   // Weight store. Writes land only while no computation is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NW; i++) begin
            w_mem[i] <= '0;
         end
      end else if (w_we && (state == S_IDLE || state == S_DONE) &&
                   (int'(w_addr) < NW)) begin
         w_mem[w_addr] <= w_data;
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         output_tensor <= '0;
         acc           <= '0;
         sc            <= '0;
         ci            <= '0;
         ky            <= '0;
         kx            <= '0;
         co            <= '0;
         oy            <= '0;
         ox            <= '0;
         for (int i = 0; i < IN_SIZE; i++) begin
            x_buf[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               // in_ready is always high here, so in_valid alone completes the handshake
               if (in_valid) begin
                  for (int i = 0; i < IN_SIZE; i++) begin
                     x_buf[i] <= input_tensor[i*DATA_WIDTH +: DATA_WIDTH];
                  end
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  acc      <= '0;
                  sc       <= '0;
                  ci       <= '0;
                  ky       <= '0;
                  kx       <= '0;
                  co       <= '0;
                  oy       <= '0;
                  ox       <= '0;
                  state    <= S_LOAD;
               end
            end

            S_LOAD: begin
               state <= S_CONV;
            end

            S_CONV: begin
               acc <= acc + prod_ext;
               // Taps are walked with kx fastest, then ky, then ci
               if (last_tap) begin
                  kx    <= '0;
                  ky    <= '0;
                  ci    <= '0;
                  state <= (USE_PROJECTION_SHORTCUT != 0) ? S_PROJ : S_WRITE;
               end else if (kx == 16'(KERNEL_SIZE - 1)) begin
                  kx <= '0;
                  if (ky == 16'(KERNEL_SIZE - 1)) begin
                     ky <= '0;
                     ci <= ci + 16'd1;
                  end else begin
                     ky <= ky + 16'd1;
                  end
               end else begin
                  kx <= kx + 16'd1;
               end
            end

            S_PROJ: begin
               sc <= sc + prod_ext;
               if (last_proj) begin
                  ci    <= '0;
                  state <= S_WRITE;
               end else begin
                  ci <= ci + 16'd1;
               end
            end

            S_WRITE: begin
               output_tensor[o_base +: DATA_WIDTH] <= q;
               acc <= '0;
               sc  <= '0;
               if (last_elem) begin
                  ox        <= '0;
                  oy        <= '0;
                  co        <= '0;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  // Output elements are produced with ox fastest, then oy, then co
                  if (ox == 16'(OUT_W - 1)) begin
                     ox <= '0;
                     if (oy == 16'(OUT_H - 1)) begin
                        oy <= '0;
                        co <= co + 16'd1;
                     end else begin
                        oy <= oy + 16'd1;
                     end
                  end else begin
                     ox <= ox + 16'd1;
                  end
                  state <= S_CONV;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
